aes_key_schedule_multi: RTL and testbench
=========================================

// Module: aes_key_schedule_multi
// PURPOSE
// - Multi-mode AES key schedule for AES-128/192/256 (FIPS-197), selected at run time.
// - Generates one 32-bit schedule word per clock and streams each completed 128-bit round key.
// - Optionally stores all round keys for random-access reads, e.g. reverse order for decryption.
// - Sits between key load logic and the encrypt/decrypt round datapath.
// PARAMETERS
// - STORE_KEYS  1   1: 15x128 round-key store + read port; 0: store and read port removed, rd_valid tied 0
// - NK_MAX      8   largest Nk supported (4, 6 or 8); key_len modes above NK_MAX are rejected as invalid
// PORTS
// - clk         in   1    clock
// - reset_n     in   1    reset, asynchronous, active-low
// - start       in   1    request expansion; sampled only in IDLE or READY
// - key_len     in   2    00=AES-128, 01=AES-192, 10=AES-256, 11=invalid
// - cipher_key  in   256  key, w0 at [255:224]; only top 32*Nk bits used
// - busy        out  1    expansion in progress
// - key_ready   out  1    full schedule valid (level)
// - err         out  1    one-cycle pulse: start rejected (invalid key_len)
// - nr          out  4    rounds of latched mode: 10/12/14; 0 after reset
// - rk_valid    out  1    one-cycle pulse: rk_data holds round key rk_idx
// - rk_idx      out  4    round index of streamed key
// - rk_data     out  128  streamed round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] at [127:96]
// - rd_en       in   1    read request to key store
// - rd_idx      in   4    round key index to read
// - rd_valid    out  1    rd_data valid; 1 cycle after rd_en
// - rd_data     out  128  stored round key rd_idx
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; word counter 0; key store cleared.
// - FSM states
//   - IDLE  --start, valid key_len--> RUN: latch key, Nk, nr; i=0
//   - IDLE  --start, key_len=11-->   IDLE: err=1 for one cycle
//   - RUN   --last word written-->   READY
//   - READY --start-->               as from IDLE; key_ready drops on the accept edge
// - Start handling
//   - start while RUN is ignored: no err, no restart.
//   - Valid start in READY also clears the old schedule.
// - Word generation: word i is written at the (i+1)th edge after the start-accept edge.
//   - Words 0..Nk-1 are the key words copied from cipher_key (w0 first), one per edge.
//   - Words i>=Nk use t = w[i-1]:
//     - i%Nk==0: t = SubWord(RotWord(t)) ^ {Rcon[i/Nk],24'h0}
//     - Nk==8 and i%8==4: t = SubWord(t)
//     - w[i] = w[i-Nk] ^ t
//   - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
//   - A sliding window of the last 8 words supplies w[i-1] and w[i-Nk]; no random read is needed.
// - Total words 4*(nr+1): 44 / 52 / 60; counter is 6-bit and stops at total-1 (no wrap).
// - Streaming
//   - rk_valid is registered: it pulses the cycle after word 4r+3 is written, once every 4 cycles.
//   - Round r=nr: key_ready rises in the same cycle as that rk_valid and busy falls.
//   - Start-accept to key_ready: AES-128 44 cycles, AES-192 52, AES-256 60.
// - Read port
//   - rd_data is registered.
//   - rd_valid=1 only if rd_idx<=nr and round rd_idx is already complete, else rd_valid=0 and rd_data holds.
//   - A read of a round completing in the same cycle returns rd_valid=0.
// - Mid-operation
//   - reset_n low aborts immediately to the reset state.
//   - cipher_key/key_len changes after accept have no effect (latched).
// STRUCTURE
// - Package aes_key_pkg holds:
//   - key_len_t enum
//   - ks_state_t enum {IDLE,RUN,READY}
//   - function nk_of(key_len_t), function nr_of(key_len_t)
//   - function rcon(idx)
//   - localparam MAX_WORDS=60
// - Sub-module aes_sub_word: 4 parallel S-box lookups on 32 bits; one instance, shared by both transform cases.
// - Top: FSM, word counter, i%Nk tracker (no divider), 8-word window, 128-bit assembly register, key store.
// TESTING
// - AES-128 key 2b7e1516 28aed2a6 abf71588 09cf4f3c
//   -> rk_idx=10 rk_data=d014f9a8c9ee2589e13f0cc8b6630ca6; key_ready at cycle 44.
// - AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b
//   -> round 12 = e98ba06f448c773c8ecc720401002202; nr=12; 52 cycles.
// - AES-256 key 603deb10...0914dff4
//   -> round 14 = fe4890d1e6188d0b046df344706c631e; 60 cycles; rk_valid exactly 15 pulses.
// - key_len=11 in IDLE -> err single pulse, busy=0, nr unchanged.
//   start pulsed at cycle 20 of RUN -> ignored, result identical to first case.
// - After AES-128 READY, reads rd_idx=10..0 back-to-back -> rd_valid=1 each cycle, matching streamed keys.
//   rd_idx=11 -> rd_valid=0.
// - reset_n low at cycle 25 of AES-256 run -> all outputs 0 next cycle.
//   New AES-128 start after release -> correct vectors.

Source files
------------

// File: rtl/aes_key_pkg.sv
// Shared types and helpers for the AES key schedule: key length modes, FSM states, Nk/Nr/Rcon lookup.
// No logic of its own; no latency or flow control.
package aes_key_pkg;

    localparam int MAX_WORDS = 60;

    typedef enum logic [1:0] {
        KL_128 = 2'b00,
        KL_192 = 2'b01,
        KL_256 = 2'b10,
        KL_INV = 2'b11
    } key_len_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        READY = 2'b10
    } ks_state_t;

    function automatic logic [3:0] nk_of(input key_len_t kl);
        case (kl)
            KL_128:  return 4'd4;
            KL_192:  return 4'd6;
            KL_256:  return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_len_t kl);
        case (kl)
            KL_128:  return 4'd10;
            KL_192:  return 4'd12;
            KL_256:  return 4'd14;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_schedule_multi_sub_word.sv
// Four parallel AES S-boxes on a 32-bit word, computed as GF(2^8) inverse plus affine map.
// Purely combinational: zero latency, no flow control.
module aes_sub_word (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};

endmodule

// File: rtl/aes_key_schedule_multi.sv
// AES-128/192/256 key schedule: one 32-bit word per clock, streams each finished round key, optional key store.
// Start-accept to key_ready is 4*(Nr+1) cycles; no backpressure, start is ignored while running.
module aes_key_schedule_multi
    import aes_key_pkg::*;
#(
    parameter int STORE_KEYS = 1,
    parameter int NK_MAX     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] cipher_key,
    output logic         busy,
    output logic         key_ready,
    output logic         err,
    output logic [3:0]   nr,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk_data,
    input  logic         rd_en,
    input  logic [3:0]   rd_idx,
    output logic         rd_valid,
    output logic [127:0] rd_data
);

    localparam int         WIN_AW = $clog2(NK_MAX);
    localparam logic [3:0] NK_LIM = 4'(NK_MAX);

    ks_state_t      state, state_nxt;
    key_len_t       kl;
    logic [5:0]     cnt;
    logic [3:0]     nk_r, nr_r, mod_r, rc_idx;
    logic [255:0]   key_sh;
    logic [31:0]    win [NK_MAX];
    logic [31:0]    sub_in, sub_out, t, w_new;
    logic [127:0]   rk_new;
    logic [WIN_AW-1:0] nk_m1;
    logic           kl_bad, start_ok, accept, reject, last, rk_done;

    assign kl       = key_len_t'(key_len);
    assign kl_bad   = (kl == KL_INV) || (nk_of(kl) > NK_LIM);
    assign start_ok = start && (state != RUN);
    assign accept   = start_ok && !kl_bad;
    assign reject   = start_ok && kl_bad;
    assign last     = (cnt == {nr_r, 2'b11});
    assign rk_done  = (state == RUN) && (cnt[1:0] == 2'b11);
    assign nk_m1    = WIN_AW'(nk_r - 4'd1);

    assign busy      = (state == RUN);
    assign key_ready = (state == READY);
    assign nr        = nr_r;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, READY: if (accept) state_nxt = RUN;
            RUN:         if (last)   state_nxt = READY;
            default:     state_nxt = IDLE;
        endcase
    end

    // One S-box bank serves both the RotWord/Rcon step and the AES-256 mid-block SubWord.
    always_comb begin
        sub_in = win[0];
        if (mod_r == 4'd0) sub_in = {win[0][23:0], win[0][31:24]};
        t = win[0];
        if (mod_r == 4'd0)                        t = sub_out ^ {rcon(rc_idx), 24'h0};
        else if (nk_r == 4'd8 && mod_r == 4'd4)   t = sub_out;
        w_new  = ({2'b00, nk_r} > cnt) ? key_sh[255:224] : (win[nk_m1] ^ t);
        rk_new = {win[2], win[1], win[0], w_new};
    end

    aes_sub_word u_sub_word (
        .din  (sub_in),
        .dout (sub_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            nk_r     <= '0;
            nr_r     <= '0;
            mod_r    <= '0;
            rc_idx   <= '0;
            key_sh   <= '0;
            err      <= 1'b0;
            rk_valid <= 1'b0;
            rk_idx   <= '0;
            rk_data  <= '0;
            for (int k = 0; k < NK_MAX; k++) win[k] <= '0;
        end else begin
            state    <= state_nxt;
            err      <= reject;
            rk_valid <= 1'b0;
            if (accept) begin
                key_sh <= cipher_key;
                nk_r   <= nk_of(kl);
                nr_r   <= nr_of(kl);
                cnt    <= '0;
                mod_r  <= '0;
                rc_idx <= '0;
            end else if (state == RUN) begin
                key_sh <= {key_sh[223:0], 32'h0};
                win[0] <= w_new;
                for (int k = 1; k < NK_MAX; k++) win[k] <= win[k-1];
                if (!last) cnt <= cnt + 6'd1;
                if (mod_r == nk_r - 4'd1) begin
                    mod_r  <= '0;
                    rc_idx <= rc_idx + 4'd1;
                end else begin
                    mod_r  <= mod_r + 4'd1;
                end
                if (rk_done) begin
                    rk_valid <= 1'b1;
                    rk_idx   <= cnt[5:2];
                    rk_data  <= rk_new;
                end
            end
        end
    end

    generate
        if (STORE_KEYS != 0) begin : g_store
            logic [127:0] store [15];
            logic [15:0]  have;

            // A round only becomes readable on the edge after it is written.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    have     <= '0;
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                    for (int k = 0; k < 15; k++) store[k] <= '0;
                end else begin
                    rd_valid <= 1'b0;
                    if (rd_en && (rd_idx <= nr_r) && have[rd_idx]) begin
                        rd_valid <= 1'b1;
                        rd_data  <= store[rd_idx];
                    end
                    if (accept) begin
                        have <= '0;
                    end else if (rk_done) begin
                        store[cnt[5:2]] <= rk_new;
                        have[cnt[5:2]]  <= 1'b1;
                    end
                end
            end
        end else begin : g_no_store
            assign rd_valid = 1'b0;
            assign rd_data  = '0;
        end
    endgenerate

endmodule

// File: tb/tb_aes_key_schedule_multi.sv
module tb_aes_key_schedule_multi;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] cipher_key;
    logic         busy, key_ready, err, rk_valid, rd_en, rd_valid;
    logic [3:0]   nr, rk_idx, rd_idx;
    logic [127:0] rk_data, rd_data;

    always #5 clk = ~clk;

    aes_key_schedule_multi #(.STORE_KEYS(1), .NK_MAX(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .key_len    (key_len),
        .cipher_key (cipher_key),
        .busy       (busy),
        .key_ready  (key_ready),
        .err        (err),
        .nr         (nr),
        .rk_valid   (rk_valid),
        .rk_idx     (rk_idx),
        .rk_data    (rk_data),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [31:0] sw(input logic [31:0] x);
        return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    endfunction

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] data;
    } rk_t;

    rk_t          exp_q [$];
    logic [127:0] exp_rk [15];
    int           pulses;
    logic [127:0] last_rk;
    rk_t          mon_e;

    task automatic model_push(input logic [1:0] kl, input logic [255:0] key);
        int nk, nrr;
        logic [31:0] w [60];
        logic [31:0] tw;
        logic [7:0]  rc;
        rk_t e;
        nk  = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
        nrr = nk + 6;
        rc  = 8'h01;
        for (int i = 0; i < 4*(nrr+1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                tw = w[i-1];
                if (i % nk == 0) begin
                    tw = sw({tw[23:0], tw[31:24]}) ^ {rc, 24'h0};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk == 8 && i % nk == 4) begin
                    tw = sw(tw);
                end
                w[i] = w[i-nk] ^ tw;
            end
        end
        for (int r = 0; r <= nrr; r++) begin
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            e.idx  = 4'(r);
            e.data = exp_rk[r];
            exp_q.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rk_valid) begin
                pulses++;
                chk("rk_pending", 128'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("rk_idx", 128'(rk_idx), 128'(mon_e.idx));
                    chk("rk_data", rk_data, mon_e.data);
                    last_rk = rk_data;
                end
            end
        end
    end

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ctl"}, 128'({busy, key_ready, err, nr, rk_valid, rk_idx, rd_valid}), 0);
        chk({tag, "_rk_data"}, rk_data, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
    endtask

    task automatic run_key(input string tag, input logic [1:0] kl, input logic [255:0] key,
                           input logic [127:0] final_rk, input int mid_start, input int abort_at);
        int cyc;
        int nr_e;
        nr_e = (kl == 2'd0) ? 10 : (kl == 2'd1) ? 12 : 14;
        @(posedge clk); #1;
        start = 1'b1; key_len = kl; cipher_key = key; pulses = 0;
        model_push(kl, key);
        @(posedge clk); #1;
        start = 1'b0; key_len = 2'b11; cipher_key = ~key;
        chk({tag, "_busy_on"}, 128'(busy), 1);
        chk({tag, "_ready_off"}, 128'(key_ready), 0);
        chk({tag, "_nr"}, 128'(nr), 128'(nr_e));
        cyc = 0;
        while (!key_ready && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (mid_start > 0 && cyc == mid_start + 1) begin
                chk({tag, "_mid_err"}, 128'(err), 0);
                chk({tag, "_mid_busy"}, 128'(busy), 1);
            end
            start = (mid_start > 0 && cyc == mid_start);
            if (start) key_len = 2'b01;
            if (abort_at > 0 && cyc == abort_at) begin
                reset_n = 1'b0;
                start   = 1'b0;
                @(negedge clk);
                chk_reset_outs({tag, "_abort"});
                exp_q.delete();
                @(posedge clk); #1;
                reset_n = 1'b1;
                return;
            end
        end
        chk({tag, "_cycles"}, 128'(cyc), 128'(4*(nr_e+1)));
        chk({tag, "_busy_off"}, 128'(busy), 0);
        @(posedge clk); #1;
        chk({tag, "_pulses"}, 128'(pulses), 128'(nr_e+1));
        chk({tag, "_q_empty"}, 128'(exp_q.size()), 0);
        chk({tag, "_final_rk"}, last_rk, final_rk);
        chk({tag, "_ready_lvl"}, 128'(key_ready), 1);
    endtask

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK128  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK192  = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] RK256  = 128'hfe4890d1e6188d0b046df344706c631e;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; key_len = 2'b00; cipher_key = '0;
        rd_en = 1'b0; rd_idx = '0; pulses = 0; last_rk = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("reset");
        #1 reset_n = 1'b1;

        // invalid key length from IDLE
        @(posedge clk); #1;
        start = 1'b1; key_len = 2'b11;
        @(posedge clk); #1;
        start = 1'b0;
        chk("inv_err_pulse", 128'(err), 1);
        chk("inv_busy", 128'(busy), 0);
        chk("inv_nr", 128'(nr), 0);
        @(posedge clk); #1;
        chk("inv_err_drop", 128'(err), 0);

        run_key("aes128", 2'b00, KEY128, RK128, 0, 0);

        for (int r = 10; r >= 0; r--) begin
            rd_en = 1'b1; rd_idx = 4'(r);
            @(posedge clk); #1;
            chk("rd_valid", 128'(rd_valid), 1);
            chk("rd_data", rd_data, exp_rk[r]);
        end
        rd_idx = 4'd11;
        @(posedge clk); #1;
        chk("rd_oob_valid", 128'(rd_valid), 0);
        chk("rd_oob_hold", rd_data, exp_rk[0]);
        rd_en = 1'b0;

        run_key("aes192", 2'b01, KEY192, RK192, 0, 0);
        run_key("aes256", 2'b10, KEY256, RK256, 0, 0);
        run_key("aes128_mid", 2'b00, KEY128, RK128, 20, 0);
        run_key("aes256_abort", 2'b10, KEY256, RK256, 0, 25);
        run_key("aes128_after", 2'b00, KEY128, RK128, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
